// File: rtl/sub_serial_16b_if.sv
// Operand/result bundle for the nibble-serial subtractor.
// master drives the request, slave returns status and results.
interface sub_serial_16b_if #(
  parameter int N = 16
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow;
  logic         ofl;
  logic         zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, ofl, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, ofl, zero
  );
endinterface

// File: rtl/sub_serial_16b.sv
// Nibble-serial a - b (a + ~b + 1) through a 4-bit CLA slice; done pulses N/4+1 cycles after start.
// No backpressure: start is only honoured in IDLE and ignored while RUN/DONE.
module sub_serial_16b #(
  parameter int N = 16
) (
  input logic            clk,
  input logic            rst,
  sub_serial_16b_if.slave bus
);

  localparam int NIB = N / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q;
  logic [CW-1:0] cnt_q;
  logic         carry_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [N-1:0] diff_q;
  logic         borrow_q;
  logic         ofl_q;
  logic         zero_q;
  logic         busy_q;
  logic         done_q;

  logic [3:0]   nib_a;
  logic [3:0]   nib_b;
  logic [3:0]   gen;
  logic [3:0]   prop;
  logic [3:0]   cla_c;
  logic         cout_d;
  logic [3:0]   sum_d;
  logic [N-1:0] diff_d;

  // Slice sees the inverted subtrahend nibble; carry_q supplies the +1 on nibble 0.
  always_comb begin
    nib_a  = a_q[{cnt_q, 2'b00} +: 4];
    nib_b  = ~b_q[{cnt_q, 2'b00} +: 4];
    gen    = nib_a & nib_b;
    prop   = nib_a ^ nib_b;
    cla_c[0] = carry_q;
    cla_c[1] = gen[0] | (prop[0] & carry_q);
    cla_c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry_q);
    cla_c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & carry_q);
    cout_d = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
           | (prop[3] & prop[2] & prop[1] & gen[0])
           | (prop[3] & prop[2] & prop[1] & prop[0] & carry_q);
    sum_d  = prop ^ cla_c;
    diff_d = diff_q;
    diff_d[{cnt_q, 2'b00} +: 4] = sum_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ofl_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          diff_q  <= diff_d;
          carry_q <= cout_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            borrow_q <= ~cout_d;
            // Top nibble is being written now, so its MSB is the result sign.
            ofl_q    <= (a_q[N-1] ^ b_q[N-1]) & (sum_d[3] ^ a_q[N-1]);
            zero_q   <= (diff_d == '0);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.ofl    = ofl_q;
  assign bus.zero   = zero_q;

endmodule
